// File: rtl/parity_checker_if.sv
// Serial-line and result bundle for the parity-frame receiver.
// PARITY_ERRCNT_EN adds the saturating err_cnt result to the bundle.
interface parity_checker_if #(
  parameter int unsigned DW = 4
);
  logic          en;
  logic          sin;
  logic [DW-1:0] data;
  logic          valid;
  logic          perr;
  logic          ferr;
  logic          busy;
`ifdef PARITY_ERRCNT_EN
  logic [7:0]    err_cnt;

  modport master (output en, sin, input data, valid, perr, ferr, busy, err_cnt);
  modport slave  (input en, sin, output data, valid, perr, ferr, busy, err_cnt);
`else
  modport master (output en, sin, input data, valid, perr, ferr, busy);
  modport slave  (input en, sin, output data, valid, perr, ferr, busy);
`endif
endinterface

// File: rtl/parity_checker.sv
// Strobed serial receiver: start, DW data bits LSB first, parity, stop; flags parity/framing errors.
// Optional PARITY_ERRCNT_EN adds a saturating 8-bit error-frame counter.
module parity_checker #(
  parameter int unsigned DW  = 4,
  parameter int unsigned ODD = 1
) (
  input logic            clk,
  input logic            rst,
  parity_checker_if.slave bus
);
  localparam int unsigned CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] shift_q, shift_d;
  logic          par_q, par_d;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          busy_q, busy_d;
`ifdef PARITY_ERRCNT_EN
  logic [7:0]    err_cnt_q, err_cnt_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef PARITY_ERRCNT_EN
      err_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
`ifdef PARITY_ERRCNT_EN
      err_cnt_q <= err_cnt_d;
`endif
    end
  end

  // Everything advances only on strobe edges; valid is a single-cycle pulse regardless.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
`ifdef PARITY_ERRCNT_EN
    err_cnt_d = err_cnt_q;
`endif
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          if (!bus.sin) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shift_d = {bus.sin, shift_q[DW-1:1]};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) state_d = PAR;
        end
        PAR: begin
          par_d   = bus.sin;
          state_d = STOP;
        end
        STOP: begin
          data_d  = shift_q;
          perr_d  = ((^{shift_q, par_q}) != 1'(ODD));
          ferr_d  = ~bus.sin;
          valid_d = 1'b1;
          state_d = IDLE;
`ifdef PARITY_ERRCNT_EN
          if ((perr_d | ferr_d) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.perr  = perr_q;
  assign bus.ferr  = ferr_q;
  assign bus.busy  = busy_q;
`ifdef PARITY_ERRCNT_EN
  assign bus.err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_parity_checker.sv
// Randomized and directed bench for parity_checker (odd and even instances on one shared line).
// Reference model works per frame on collected bits; PARITY_ERRCNT_EN also checks err_cnt.
module tb_parity_checker;
  localparam int unsigned DW = 4;

  logic clk;
  logic rst;

  parity_checker_if #(.DW(DW)) if_o ();
  parity_checker_if #(.DW(DW)) if_e ();

  parity_checker #(.DW(DW), .ODD(1)) u_odd  (.clk(clk), .rst(rst), .bus(if_o.slave));
  parity_checker #(.DW(DW), .ODD(0)) u_even (.clk(clk), .rst(rst), .bus(if_e.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level reference state
  bit in_frame;
  int nbits, word, par_b;
  int exp_valid, exp_busy, exp_data, exp_perr_o, exp_perr_e, exp_ferr;
`ifdef PARITY_ERRCNT_EN
  int exp_cnt_o, exp_cnt_e;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_frame = 0; nbits = 0; word = 0; par_b = 0;
    exp_valid = 0; exp_busy = 0; exp_data = 0;
    exp_perr_o = 0; exp_perr_e = 0; exp_ferr = 0;
`ifdef PARITY_ERRCNT_EN
    exp_cnt_o = 0; exp_cnt_e = 0;
`endif
  endtask

  task automatic model_strobe(input int b);
    int ones;
    exp_valid = 0;
    if (!in_frame) begin
      if (b == 0) begin in_frame = 1; nbits = 1; word = 0; end
    end else begin
      nbits++;
      if (nbits <= DW + 1) word = word + (b << (nbits - 2));
      else if (nbits == DW + 2) par_b = b;
      else begin
        ones       = $countones(word) + par_b;
        exp_data   = word;
        exp_perr_o = (ones % 2 == 0) ? 1 : 0;
        exp_perr_e = (ones % 2 == 1) ? 1 : 0;
        exp_ferr   = (b == 0) ? 1 : 0;
        exp_valid  = 1;
        in_frame   = 0;
`ifdef PARITY_ERRCNT_EN
        if ((exp_perr_o | exp_ferr) != 0 && exp_cnt_o < 255) exp_cnt_o++;
        if ((exp_perr_e | exp_ferr) != 0 && exp_cnt_e < 255) exp_cnt_e++;
`endif
      end
    end
    exp_busy = in_frame ? 1 : 0;
  endtask

  task automatic check_all();
    check("valid_o", 32'(if_o.valid), 32'(exp_valid));
    check("valid_e", 32'(if_e.valid), 32'(exp_valid));
    check("busy_o",  32'(if_o.busy),  32'(exp_busy));
    check("busy_e",  32'(if_e.busy),  32'(exp_busy));
    check("data_o",  32'(if_o.data),  32'(exp_data));
    check("data_e",  32'(if_e.data),  32'(exp_data));
    check("perr_o",  32'(if_o.perr),  32'(exp_perr_o));
    check("perr_e",  32'(if_e.perr),  32'(exp_perr_e));
    check("ferr_o",  32'(if_o.ferr),  32'(exp_ferr));
    check("ferr_e",  32'(if_e.ferr),  32'(exp_ferr));
`ifdef PARITY_ERRCNT_EN
    check("err_cnt_o", 32'(if_o.err_cnt), 32'(exp_cnt_o));
    check("err_cnt_e", 32'(if_e.err_cnt), 32'(exp_cnt_e));
`endif
  endtask

  task automatic set_in(input logic e, input logic s);
    if_o.en = e; if_o.sin = s;
    if_e.en = e; if_e.sin = s;
  endtask

  // gap non-strobe cycles (with a wandering sin) precede each strobed bit
  task automatic strobe(input int b, input int gap);
    for (int i = 0; i < gap; i++) begin
      set_in(1'b0, 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      exp_valid = 0;
      check_all();
    end
    set_in(1'b1, 1'(b));
    @(posedge clk); #1;
    model_strobe(b);
    check_all();
    set_in(1'b0, 1'b1);
  endtask

  task automatic send_frame(input int w, input int p, input int stop, input int gap);
    strobe(0, gap);
    for (int i = 0; i < int'(DW); i++) strobe((w >> i) & 1, gap);
    strobe(p, gap);
    strobe(stop, gap);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) strobe(1, 0);
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;

    // 1: 4'hB, odd parity ok (even instance flags)
    send_frame(4'hB, 0, 1, 0);
    send_idle(2);
    // 2: same word, parity bit 1 (even instance clean)
    send_frame(4'hB, 1, 1, 0);
    // 3: 4'h5 with bad stop bit, then idle line
    send_frame(4'h5, 1, 0, 0);
    send_idle(5);
    // 4: strobe every third cycle
    send_frame(4'hF, 1, 1, 2);
    send_idle(1);
    // 5: reset mid-frame after two data bits
    strobe(0, 0); strobe(1, 0); strobe(0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    rst = 1'b0;
    send_frame(4'h0, 1, 1, 0);
    // 6: back-to-back frames
    send_frame(4'h3, 1, 1, 0);
    send_frame(4'hC, 1, 1, 0);
    send_idle(1);

    // randomized frames, gaps and idle bits
    for (int n = 0; n < 80; n++) begin
      send_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 2)));
      send_idle(int'($urandom_range(0, 2)));
    end

`ifdef PARITY_ERRCNT_EN
    // drive the error counters into saturation
    for (int n = 0; n < 260; n++) send_frame(int'($urandom_range(0, 15)), 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/parity_checker.md
Name: parity_checker

Overview:
Serial receiver and checker for parity-protected nibble frames. It is the receive end of the parity generator.
- Deserialises a frame of start bit, DW data bits (LSB first), parity bit and stop bit.
- Checks the parity against the configured sense and flags framing errors.
- Sits after a bit-rate strobe generator. Each frame yields one result, signalled by a one-cycle `valid` pulse.

Parameters:
- DW, 4, number of data bits per frame (2..16).
- ODD, 1, parity sense: 1 = odd parity, so the count of ones in data plus parity bit must be odd; 0 = even parity.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  bit strobe; sin is sampled only on rising edges where en=1.
- sin  input  1  serial line; idles high.
- data  output  DW  last received data word, LSB = first data bit received.
- valid  output  1  one-cycle pulse when a frame completes.
- perr  output  1  parity error of the last frame.
- ferr  output  1  framing error (stop bit = 0) of the last frame.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset values: state=IDLE; data, valid, perr, ferr, busy and the internal shift register and bit counter all 0. Reset is asynchronous and honoured mid-frame; the partial frame is discarded.
- en=0 on a clock edge: state, counter, shift register and outputs hold. The exception is valid, which clears after its single cycle.
- States (transitions occur only on edges with en=1):
  - IDLE: sin=0 -> DATA, cnt=0. sin=1 -> stay in IDLE.
  - DATA: shift sin into the word LSB-first, cnt=cnt+1. After the DW-th bit, go to PAR.
  - PAR: capture the parity bit p, go to STOP.
  - STOP: sample the stop bit, load the outputs, go to IDLE.
- Output update on the STOP sampling edge:
  - data <= received word.
  - perr <= (^{word,p}) != ODD.
  - ferr <= ~sin.
  - valid <= 1 for exactly one clock.
- perr and ferr are both evaluated independently on every frame.
- data, perr and ferr hold until the next frame completes.
- Latency: valid rises on the same edge that samples the stop bit. The bit counter is sized $clog2(DW+1) and never wraps within a frame.
- A start bit sampled on the strobe right after STOP is accepted, so back-to-back frames are supported with no idle bit.
- No glitch filtering: a single low sample in IDLE starts a frame.
- The input is synchronous to clk; the external strobe source handles any synchronisation.

Optional Feature:
- PARITY_ERRCNT_EN defined:
  - Adds output port `err_cnt`, 8 bits.
  - err_cnt increments by 1 on each completed frame with perr|ferr, and saturates at 255.
  - It is cleared only by rst.
- PARITY_ERRCNT_EN undefined: no err_cnt port and no counter logic. All other behaviour is identical.

Test Plan:
1. ODD=1, en=1 every cycle, sin sequence 0,1,1,0,1,0,1 -> valid pulses once on the 7th edge; data=4'hB, perr=0, ferr=0; busy low afterwards.
2. Same frame with parity bit 1 (0,1,1,0,1,1,1) -> data=4'hB, perr=1, ferr=0; err_cnt=1 if PARITY_ERRCNT_EN is defined.
3. Frame 4'h5 with correct parity and stop bit 0 (0,1,0,1,0,1,0) -> data=4'h5, perr=0, ferr=1. Then sin held high -> stays IDLE with valid=0.
4. en high only every 3rd cycle; frame 4'hF with parity 1 -> same result as the continuous case (data=4'hF, no errors). valid lasts exactly one clock, and outputs hold between strobes.
5. rst pulsed after the 2nd data bit of a frame -> all outputs 0 and busy=0 immediately. Next frame 4'h0 with parity 1 -> data=4'h0, perr=0, ferr=0.
6. Back-to-back frames 4'h3 then 4'hC with no idle bit between them -> two valid pulses 7 strobes apart, with data=4'h3 then 4'hC and no errors. With ODD=0, rerun scenario 1 using parity bit 1 -> perr=0.
